// File: rtl/fact_accel.sv
// Iterative factorial engine: n! modulo 2^WIDTH computed with one WIDTH x N_WIDTH multiply per cycle.
// Optional overflow detection is compiled in with the FACT_ACCEL_OVF_EN macro; without it overflow reads 0.
module fact_accel #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [N_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]   prod_lo;
  logic               last_step;

  assign last_step = (cnt <= N_WIDTH'(1));

`ifdef FACT_ACCEL_OVF_EN
  localparam int PW = WIDTH + N_WIDTH;

  logic [PW-1:0] prod_full;
  logic          ovf_step;
  logic          ovf_sticky;

  assign prod_full = PW'(acc) * PW'(cnt);
  assign prod_lo   = prod_full[WIDTH-1:0];
  assign ovf_step  = |prod_full[PW-1:WIDTH];

  // Sticky flag gathers every lost upper product bit; it is published with the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        ovf_sticky <= 1'b0;
        overflow   <= 1'b0;
      end else if (state == CALC) begin
        if (!last_step) begin
          ovf_sticky <= ovf_sticky | ovf_step;
        end else begin
          overflow <= ovf_sticky;
        end
      end
    end
  end
`else
  assign prod_lo  = acc * WIDTH'(cnt);
  assign overflow = 1'b0;
`endif

  // busy is raised only for operands that need at least one multiply, so the
  // trivial n=0/1 pass through CALC never shows busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            acc   <= WIDTH'(1);
            cnt   <= n;
            busy  <= (n > N_WIDTH'(1));
          end
        end
        CALC: begin
          if (!last_step) begin
            acc <= prod_lo;
            cnt <= cnt - N_WIDTH'(1);
          end else begin
            result <= acc;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_accel.sv
// Scoreboard bench for fact_accel: the driver queues hand-computed results, a monitor checks each done pulse.
module tb_fact_accel;
  localparam int WIDTH   = 32;
  localparam int N_WIDTH = 5;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [N_WIDTH-1:0] n = '0;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               overflow;

  fact_accel #(.WIDTH(WIDTH), .N_WIDTH(N_WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .n(n),
    .busy(busy),
    .done(done),
    .result(result),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             ovf;
    int               done_cyc;
    int               busy_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   busy_run = 0;

  // Hand-computed factorials 0!..12! (all fit in 32 bits).
  logic [31:0] fact_tab [0:12] = '{32'd1, 32'd1, 32'd2, 32'd6, 32'd24, 32'd120, 32'd720,
                                   32'd5040, 32'd40320, 32'd362880, 32'd3628800,
                                   32'd39916800, 32'd479001600};

`ifdef FACT_ACCEL_OVF_EN
  localparam logic OVF13 = 1'b1;
`else
  localparam logic OVF13 = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        n_done++;
        check("busy_done_excl", {63'd0, busy}, 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("result", {32'd0, result}, {32'd0, e.res});
          check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
          check("done_latency", 64'(cyc), 64'(e.done_cyc));
          check("busy_cycles", 64'(busy_run), 64'(e.busy_cyc));
        end
        busy_run = 0;
      end
    end
  end

  function automatic int lat(input int nv);
    return (nv > 1) ? nv : 1;
  endfunction

  function automatic int bcyc(input int nv);
    return (nv > 1) ? nv : 0;
  endfunction

  task automatic push_exp(input logic [31:0] r, input logic o, input int dc, input int bc);
    exp_t e;
    e.res = r;
    e.ovf = o;
    e.done_cyc = dc;
    e.busy_cyc = bc;
    sb.push_back(e);
  endtask

  task automatic launch(input int nv, input logic [31:0] r, input logic o);
    @(negedge clk);
    start = 1'b1;
    n = N_WIDTH'(nv);
    push_exp(r, o, cyc + 1 + lat(nv), bcyc(nv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < budget);
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int d0;
    // Reset is asserted before any clock edge, so outputs must already be clear.
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    launch(5, 32'd120, 1'b0);
    drain(40);
    launch(0, 32'd1, 1'b0);
    drain(40);
    launch(1, 32'd1, 1'b0);
    drain(40);
    launch(12, 32'd479001600, 1'b0);
    drain(40);
    launch(13, 32'd1932053504, OVF13);
    drain(40);

    // A second request during CALC must be dropped.
    @(negedge clk);
    start = 1'b1;
    n = N_WIDTH'(6);
    push_exp(32'd720, 1'b0, cyc + 1 + 6, 6);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    n = N_WIDTH'(3);
    @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (10) @(negedge clk);

    // Asynchronous abort mid-operation.
    @(negedge clk);
    start = 1'b1;
    n = N_WIDTH'(10);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", {32'd0, result}, 64'd0);
    check("abort_overflow", {63'd0, overflow}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (15) @(negedge clk);
    launch(4, 32'd24, 1'b0);
    drain(40);

    // Back-to-back sweep with start held high; n is updated as each done appears.
    d0 = n_done;
    @(negedge clk);
    start = 1'b1;
    n = '0;
    push_exp(fact_tab[0], 1'b0, cyc + 1 + lat(0), bcyc(0));
    for (int k = 1; k <= 12; k++) begin
      wait_done(40);
      n = N_WIDTH'(k);
      push_exp(fact_tab[k], 1'b0, cyc + 2 + lat(k), bcyc(k));
    end
    wait_done(40);
    start = 1'b0;
    drain(40);
    check("sweep_done_count", 64'(n_done - d0), 64'd13);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
